// File: rtl/experiment_round_sequencer_pkg.sv
// Shared types and constants for the experiment round sequencer: state encoding,
// status word bit positions and default widths.
package experiment_round_sequencer_pkg;

    localparam int NUM_DAC_DEF   = 9;
    localparam int ROUND_W_DEF   = 16;
    localparam int BEAT_W_DEF    = 12;
    localparam int TIMEOUT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_FINISH  = 3'd4
    } seq_state_e;

    localparam int STAT_STATE_LSB     = 29;
    localparam int STAT_BUSY_BIT      = 28;
    localparam int STAT_TERR_BIT      = 27;
    localparam int STAT_DONE_SEEN_BIT = 26;
    localparam int STAT_ROUND_LSB     = 0;

    // First phase of a round once zero-length phases are skipped; an all-zero
    // round still spends one CAPTURE cycle so rounds advance one per cycle.
    function automatic seq_state_e first_phase(input logic play_zero, input logic settle_zero);
        if (!play_zero) begin
            return ST_PLAY;
        end else if (!settle_zero) begin
            return ST_SETTLE;
        end else begin
            return ST_CAPTURE;
        end
    endfunction

endpackage

// File: rtl/experiment_round_sequencer_if.sv
// DAC/ADC stream handshake bundle between the round sequencer and the stream ports.
interface experiment_round_sequencer_if #(
    parameter int NUM_DAC = 9
);
    logic [NUM_DAC-1:0] dac_tready;
    logic [NUM_DAC-1:0] dac_tvalid;
    logic               dac_beat;
    logic               adc_tvalid;
    logic               adc_tready;
    logic               cap_beat;

    modport master (
        input  dac_tready, adc_tvalid,
        output dac_tvalid, dac_beat, adc_tready, cap_beat
    );

    modport slave (
        output dac_tready, adc_tvalid,
        input  dac_tvalid, dac_beat, adc_tready, cap_beat
    );
endinterface

// File: rtl/experiment_round_sequencer_phase_counter.sv
// Loadable down-counter for one sequencer phase: flags a zero target (phase is
// skipped) and the final counted event of the phase.
module seq_phase_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         skip,
    output logic         last
);
    logic [W-1:0] cnt_r;

    // Remaining events in the current phase; holds at zero rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign skip = (load_val == '0);
    assign last = en && (cnt_r == W'(1));

endmodule

// File: rtl/experiment_round_sequencer.sv
// Round sequencer for one Ising-machine run: PLAY -> SETTLE -> CAPTURE per round.
// Optional status_word output enabled by EXPERIMENT_SEQ_STATUS_EN.
module experiment_round_sequencer
    import experiment_round_sequencer_pkg::*;
#(
    parameter int NUM_DAC   = NUM_DAC_DEF,
    parameter int ROUND_W   = ROUND_W_DEF,
    parameter int BEAT_W    = BEAT_W_DEF,
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ROUND_W-1:0]   cfg_num_rounds,
    input  logic [BEAT_W-1:0]    cfg_play_beats,
    input  logic [BEAT_W-1:0]    cfg_settle_cycles,
    input  logic [BEAT_W-1:0]    cfg_cap_beats,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    experiment_round_sequencer_if.master strm,
    output logic [ROUND_W-1:0]   round_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
`ifdef EXPERIMENT_SEQ_STATUS_EN
    ,
    output logic [31:0]          status_word
`endif
);

    seq_state_e state_r, next_state_s;

    logic [ROUND_W-1:0]   rounds_r, round_r, round_next_s, re_round_s;
    logic [BEAT_W-1:0]    play_r, settle_r, cap_r;
    logic [BEAT_W-1:0]    play_tgt_s, settle_tgt_s, cap_tgt_s;
    logic [TIMEOUT_W-1:0] timeout_r, cyc_r, cyc_next_s;
    logic [TIMEOUT_W:0]   cyc_inc_s;
    logic [ROUND_W:0]     round_inc_s;

    logic dac_tvalid_r, adc_tready_r, busy_r, done_r, terr_r;
    logic dac_beat_s, cap_beat_s;
    logic play_zero_s, settle_zero_s, cap_zero_s;
    logic play_last_s, settle_last_s, cap_last_s;
    logic load_play_s, load_settle_s, load_cap_s;
    logic cap_done_s, timeout_hit_s, last_round_s;
    logic start_run_s, done_next_s, terr_next_s;
    seq_state_e re_state_s;

    assign dac_beat_s = dac_tvalid_r & (&strm.dac_tready);
    assign cap_beat_s = adc_tready_r & strm.adc_tvalid;

    // In IDLE the skip decisions must see the config being latched this cycle.
    assign play_tgt_s   = (state_r == ST_IDLE) ? cfg_play_beats    : play_r;
    assign settle_tgt_s = (state_r == ST_IDLE) ? cfg_settle_cycles : settle_r;
    assign cap_tgt_s    = (state_r == ST_IDLE) ? cfg_cap_beats     : cap_r;

    seq_phase_counter #(.W(BEAT_W)) u_play_cnt (
        .clk(clk), .rst(rst), .load(load_play_s), .load_val(play_tgt_s),
        .en(dac_beat_s), .skip(play_zero_s), .last(play_last_s)
    );

    seq_phase_counter #(.W(BEAT_W)) u_settle_cnt (
        .clk(clk), .rst(rst), .load(load_settle_s), .load_val(settle_tgt_s),
        .en(state_r == ST_SETTLE), .skip(settle_zero_s), .last(settle_last_s)
    );

    seq_phase_counter #(.W(BEAT_W)) u_cap_cnt (
        .clk(clk), .rst(rst), .load(load_cap_s), .load_val(cap_tgt_s),
        .en(cap_beat_s), .skip(cap_zero_s), .last(cap_last_s)
    );

    assign round_inc_s   = {1'b0, round_r} + {{ROUND_W{1'b0}}, 1'b1};
    assign last_round_s  = (round_inc_s == {1'b0, rounds_r});
    assign re_state_s    = last_round_s ? ST_FINISH : first_phase(play_zero_s, settle_zero_s);
    assign re_round_s    = last_round_s ? round_r : round_inc_s[ROUND_W-1:0];

    assign cyc_inc_s     = {1'b0, cyc_r} + {{TIMEOUT_W{1'b0}}, 1'b1};
    assign cap_done_s    = (state_r == ST_CAPTURE) && (cap_last_s || cap_zero_s);
    assign timeout_hit_s = (state_r == ST_CAPTURE) && (timeout_r != '0) &&
                           (cyc_inc_s == {1'b0, timeout_r});

    // Next-state decision; abort overrides everything outside IDLE.
    always_comb begin
        next_state_s = state_r;
        round_next_s = round_r;
        terr_next_s  = terr_r;
        done_next_s  = 1'b0;
        start_run_s  = 1'b0;
        if (abort && (state_r != ST_IDLE)) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        start_run_s  = 1'b1;
                        terr_next_s  = 1'b0;
                        round_next_s = '0;
                        if (cfg_num_rounds == '0) begin
                            next_state_s = ST_FINISH;
                        end else begin
                            next_state_s = first_phase(play_zero_s, settle_zero_s);
                        end
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (!play_last_s) begin
                        next_state_s = ST_PLAY;
                    end else if (!settle_zero_s) begin
                        next_state_s = ST_SETTLE;
                    end else if (!cap_zero_s) begin
                        next_state_s = ST_CAPTURE;
                    end else begin
                        next_state_s = re_state_s;
                        round_next_s = re_round_s;
                    end
                end
                ST_SETTLE: begin
                    if (!settle_last_s) begin
                        next_state_s = ST_SETTLE;
                    end else if (!cap_zero_s) begin
                        next_state_s = ST_CAPTURE;
                    end else begin
                        next_state_s = re_state_s;
                        round_next_s = re_round_s;
                    end
                end
                ST_CAPTURE: begin
                    // Completion is checked first so a coincident timeout loses.
                    if (cap_done_s) begin
                        next_state_s = re_state_s;
                        round_next_s = re_round_s;
                    end else if (timeout_hit_s) begin
                        next_state_s = ST_IDLE;
                        terr_next_s  = 1'b1;
                    end else begin
                        next_state_s = ST_CAPTURE;
                    end
                end
                ST_FINISH: begin
                    next_state_s = ST_IDLE;
                    done_next_s  = 1'b1;
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // A phase reloads on entry, including re-entry straight from its own last event.
    assign load_play_s   = (next_state_s == ST_PLAY)    && ((state_r != ST_PLAY)    || play_last_s);
    assign load_settle_s = (next_state_s == ST_SETTLE)  && ((state_r != ST_SETTLE)  || settle_last_s);
    assign load_cap_s    = (next_state_s == ST_CAPTURE) && ((state_r != ST_CAPTURE) || cap_done_s);

    // Capture cycle counter: zero on entry, saturating while the round stays in CAPTURE.
    always_comb begin
        if ((state_r == ST_CAPTURE) && (next_state_s == ST_CAPTURE) && !cap_done_s) begin
            cyc_next_s = cyc_inc_s[TIMEOUT_W] ? cyc_r : cyc_inc_s[TIMEOUT_W-1:0];
        end else begin
            cyc_next_s = '0;
        end
    end

    // Sequencer state, latched config and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            rounds_r     <= '0;
            play_r       <= '0;
            settle_r     <= '0;
            cap_r        <= '0;
            timeout_r    <= '0;
            cyc_r        <= '0;
            round_r      <= '0;
            dac_tvalid_r <= 1'b0;
            adc_tready_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            terr_r       <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            cyc_r        <= cyc_next_s;
            round_r      <= round_next_s;
            dac_tvalid_r <= (next_state_s == ST_PLAY);
            adc_tready_r <= (next_state_s == ST_CAPTURE);
            busy_r       <= (next_state_s != ST_IDLE);
            done_r       <= done_next_s;
            terr_r       <= terr_next_s;
            if (start_run_s) begin
                rounds_r  <= cfg_num_rounds;
                play_r    <= cfg_play_beats;
                settle_r  <= cfg_settle_cycles;
                cap_r     <= cfg_cap_beats;
                timeout_r <= cfg_timeout;
            end
        end
    end

    assign strm.dac_tvalid = {NUM_DAC{dac_tvalid_r}};
    assign strm.dac_beat   = dac_beat_s;
    assign strm.adc_tready = adc_tready_r;
    assign strm.cap_beat   = cap_beat_s;
    assign round_idx       = round_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign timeout_err     = terr_r;

`ifdef EXPERIMENT_SEQ_STATUS_EN
    logic        done_seen_r, done_seen_next_s;
    logic [31:0] status_r, status_next_s;

    // Status word is assembled from next-cycle values so its fields stay coherent.
    always_comb begin
        if (start_run_s) begin
            done_seen_next_s = 1'b0;
        end else if (done_next_s) begin
            done_seen_next_s = 1'b1;
        end else begin
            done_seen_next_s = done_seen_r;
        end
        status_next_s                          = 32'h0000_0000;
        status_next_s[STAT_STATE_LSB +: 3]     = next_state_s;
        status_next_s[STAT_BUSY_BIT]           = (next_state_s != ST_IDLE);
        status_next_s[STAT_TERR_BIT]           = terr_next_s;
        status_next_s[STAT_DONE_SEEN_BIT]      = done_seen_next_s;
        status_next_s[STAT_ROUND_LSB +: 16]    = 16'(round_next_s);
    end

    // Registered GPIO status word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_seen_r <= 1'b0;
            status_r    <= 32'h0000_0000;
        end else begin
            done_seen_r <= done_seen_next_s;
            status_r    <= status_next_s;
        end
    end

    assign status_word = status_r;
`endif

endmodule
